// File: rtl/btb_ctrl_pkg.sv
// Shared geometry, way field layout and FSM encodings for the 8-set, 2-way BTB control stage.
package btb_ctrl_pkg;

   localparam int BTB_SETS  = 8;
   localparam int BTB_WAYS  = 2;
   localparam int IDX_W     = 3;
   localparam int TAG_W     = 27;
   localparam int WAY_W     = 64;
   localparam int SET_W     = WAY_W * BTB_WAYS;

   localparam int VALID_BIT = 63;
   localparam int TAG_MSB   = 62;
   localparam int TAG_LSB   = 36;
   localparam int TGT_MSB   = 35;
   localparam int TGT_LSB   = 4;
   localparam int RSVD_BIT  = 3;
   localparam int LRU_BIT   = 2;
   localparam int CTR_MSB   = 1;
   localparam int CTR_LSB   = 0;

   localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } btb_state_t;

   // Two-bit saturating counter step toward the resolved direction.
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/btb_way_update.sv
// Computes the replacement contents of one BTB way from its current contents and the update controls.
module btb_way_update
   import btb_ctrl_pkg::*;
(
   input  logic [WAY_W-1:0] way_in,
   input  logic             hit,
   input  logic             alloc,
   input  logic             taken,
   input  logic [TAG_W-1:0] tag,
   input  logic [31:0]      target,
   input  logic             lru_val,
   output logic [WAY_W-1:0] way_out
);

   // Allocation rewrites the whole way; a hit only trains the counter and, when taken, the target.
   always_comb begin
      way_out = way_in;
      if (alloc) begin
         way_out[VALID_BIT]        = 1'b1;
         way_out[TAG_MSB:TAG_LSB]  = tag;
         way_out[TGT_MSB:TGT_LSB]  = target;
         way_out[CTR_MSB:CTR_LSB]  = CTR_WEAK_TAKEN;
      end else if (hit) begin
         way_out[CTR_MSB:CTR_LSB]  = ctr_next(way_in[CTR_MSB:CTR_LSB], taken);
         if (taken) begin
            way_out[TGT_MSB:TGT_LSB] = target;
         end else begin
            way_out[TGT_MSB:TGT_LSB] = way_in[TGT_MSB:TGT_LSB];
         end
      end else begin
         way_out = way_in;
      end
      way_out[RSVD_BIT] = 1'b0;
      way_out[LRU_BIT]  = lru_val;
   end

endmodule

// File: rtl/btb_ctrl.sv
// BTB control stage: post-reset clear sweep, fetch prediction, and resolved-branch set update.
module btb_ctrl
   import btb_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      fetch_pc,
   input  logic [SET_W-1:0] read_set,
   input  logic [SET_W-1:0] update_set,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic [31:0]      upd_target,
   input  logic             upd_taken,
   output logic [IDX_W-1:0] read_index,
   output logic [IDX_W-1:0] update_index,
   output logic [IDX_W-1:0] write_index,
   output logic [SET_W-1:0] write_set,
   output logic             write_en,
   output logic             predict_taken,
   output logic [31:0]      predict_target,
   output logic             btb_ready
);

   btb_state_t       state_r;
   logic [IDX_W-1:0] init_cnt_r;
   logic             q_valid_r;
   logic [31:2]      q_pc_r;
   logic [31:0]      q_target_r;
   logic             q_taken_r;

   logic [TAG_W-1:0] q_tag_s;
   logic [WAY_W-1:0] u_w0_s;
   logic [WAY_W-1:0] u_w1_s;
   logic             u_hit0_s;
   logic             u_hit1_s;
   logic             u_hit_s;
   logic             victim1_s;
   logic             alloc0_s;
   logic             alloc1_s;
   logic             touched1_s;
   logic             upd_we_s;
   logic [WAY_W-1:0] w0_new_s;
   logic [WAY_W-1:0] w1_new_s;

   logic [TAG_W-1:0] f_tag_s;
   logic [WAY_W-1:0] r_w0_s;
   logic [WAY_W-1:0] r_w1_s;
   logic             p_hit0_s;
   logic             p_hit1_s;
   logic             unused_s;

   // FSM, sweep counter and the single-entry update register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= INIT;
         init_cnt_r <= 3'd0;
         q_valid_r  <= 1'b0;
         q_pc_r     <= 30'd0;
         q_target_r <= 32'd0;
         q_taken_r  <= 1'b0;
      end else begin
         case (state_r)
            INIT: begin
               init_cnt_r <= init_cnt_r + 3'd1;
               if (init_cnt_r == 3'd7) begin
                  state_r <= RUN;
               end else begin
                  state_r <= INIT;
               end
            end
            RUN:     state_r <= RUN;
            default: state_r <= INIT;
         endcase
         q_valid_r <= upd_valid && (state_r == RUN);
         if (upd_valid && (state_r == RUN)) begin
            q_pc_r     <= upd_pc[31:2];
            q_target_r <= upd_target;
            q_taken_r  <= upd_taken;
         end
      end
   end

   assign q_tag_s      = q_pc_r[31:5];
   assign update_index = q_pc_r[4:2];
   assign read_index   = fetch_pc[4:2];
   assign u_w0_s       = update_set[WAY_W-1:0];
   assign u_w1_s       = update_set[SET_W-1:WAY_W];

   // Hit detection and victim choice for the queued update; way0 wins a double hit.
   always_comb begin
      u_hit0_s = u_w0_s[VALID_BIT] && (u_w0_s[TAG_MSB:TAG_LSB] == q_tag_s);
      u_hit1_s = u_w1_s[VALID_BIT] && (u_w1_s[TAG_MSB:TAG_LSB] == q_tag_s) && !u_hit0_s;
      u_hit_s  = u_hit0_s || u_hit1_s;
      if (!u_w0_s[VALID_BIT]) begin
         victim1_s = 1'b0;
      end else if (!u_w1_s[VALID_BIT]) begin
         victim1_s = 1'b1;
      end else begin
         victim1_s = u_w0_s[LRU_BIT];
      end
      alloc0_s   = !u_hit_s && q_taken_r && !victim1_s;
      alloc1_s   = !u_hit_s && q_taken_r && victim1_s;
      touched1_s = u_hit1_s || alloc1_s;
      upd_we_s   = q_valid_r && (state_r == RUN) && (u_hit_s || q_taken_r);
   end

   // The LRU bit lives in way0 and names the way not touched by this update.
   btb_way_update u_way0 (
      .way_in  (u_w0_s),
      .hit     (u_hit0_s),
      .alloc   (alloc0_s),
      .taken   (q_taken_r),
      .tag     (q_tag_s),
      .target  (q_target_r),
      .lru_val (!touched1_s),
      .way_out (w0_new_s)
   );

   btb_way_update u_way1 (
      .way_in  (u_w1_s),
      .hit     (u_hit1_s),
      .alloc   (alloc1_s),
      .taken   (q_taken_r),
      .tag     (q_tag_s),
      .target  (q_target_r),
      .lru_val (1'b0),
      .way_out (w1_new_s)
   );

   // Write port: clearing sweep in INIT, trained set in RUN.
   always_comb begin
      write_en    = 1'b1;
      write_index = init_cnt_r;
      write_set   = {SET_W{1'b0}};
      btb_ready   = 1'b0;
      case (state_r)
         INIT: begin
            write_en    = 1'b1;
            write_index = init_cnt_r;
            write_set   = {SET_W{1'b0}};
            btb_ready   = 1'b0;
         end
         RUN: begin
            write_en    = upd_we_s;
            write_index = q_pc_r[4:2];
            write_set   = {w1_new_s, w0_new_s};
            btb_ready   = 1'b1;
         end
         default: begin
            write_en    = 1'b1;
            write_index = init_cnt_r;
            write_set   = {SET_W{1'b0}};
            btb_ready   = 1'b0;
         end
      endcase
   end

   assign f_tag_s = fetch_pc[31:5];
   assign r_w0_s  = read_set[WAY_W-1:0];
   assign r_w1_s  = read_set[SET_W-1:WAY_W];

   // Zero-latency prediction from the fetched set; silent until the sweep completes.
   always_comb begin
      p_hit0_s       = r_w0_s[VALID_BIT] && (r_w0_s[TAG_MSB:TAG_LSB] == f_tag_s);
      p_hit1_s       = r_w1_s[VALID_BIT] && (r_w1_s[TAG_MSB:TAG_LSB] == f_tag_s);
      predict_taken  = 1'b0;
      predict_target = 32'd0;
      if (state_r != RUN) begin
         predict_taken  = 1'b0;
         predict_target = 32'd0;
      end else if (p_hit0_s) begin
         predict_taken  = r_w0_s[CTR_MSB];
         predict_target = r_w0_s[TGT_MSB:TGT_LSB];
      end else if (p_hit1_s) begin
         predict_taken  = r_w1_s[CTR_MSB];
         predict_target = r_w1_s[TGT_MSB:TGT_LSB];
      end else begin
         predict_taken  = 1'b0;
         predict_target = 32'd0;
      end
   end

   assign unused_s = ^{fetch_pc[1:0], upd_pc[1:0],
                       read_set[RSVD_BIT:LRU_BIT], read_set[CTR_LSB],
                       read_set[WAY_W+RSVD_BIT:WAY_W+LRU_BIT], read_set[WAY_W+CTR_LSB]};

endmodule
